// File: rtl/bht_branch_predictor.sv
// Fetch-side direction/target predictor backed by a 2-bit saturating-counter BHT.
// After reset, an init sweep writes INIT_CTR into every entry. Execute-stage
// resolutions then train the table and update the statistics counters.
module bht_branch_predictor #(
    parameter int unsigned IDX_BITS = 6,
    parameter logic [1:0]  INIT_CTR = 2'b01,
    parameter int unsigned STAT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [31:0]       if_pc,
    input  logic [31:0]       if_instr,
    input  logic [31:0]       if_imm,
    output logic              pred_taken,
    output logic [31:0]       pred_target,
    input  logic              ex_valid,
    input  logic [31:0]       ex_pc,
    input  logic              ex_is_branch,
    input  logic              ex_taken,
    input  logic              ex_mispredict,
    output logic              ready,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispredicts
);

    localparam int unsigned ENTRIES = 1 << IDX_BITS;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [6:0]  OPC_JAL    = 7'b1101111;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [IDX_BITS-1:0] init_idx;
    logic [IDX_BITS-1:0] init_idx_next;
    logic                ready_next;

    logic [1:0]          bht [ENTRIES];

    logic [IDX_BITS-1:0] if_idx;
    logic [IDX_BITS-1:0] ex_idx;
    logic [6:0]          if_opc;
    logic [1:0]          if_ctr;
    logic [1:0]          ex_ctr;
    logic [1:0]          ex_ctr_upd;
    logic                train;

    // Bits of the PCs and instruction that take no part in prediction or training
    logic unused_bits;
    assign unused_bits = ^{if_instr[31:7], ex_pc[31:IDX_BITS+2], ex_pc[1:0]};

    assign if_idx = if_pc[IDX_BITS+1:2];
    assign ex_idx = ex_pc[IDX_BITS+1:2];
    assign if_opc = if_instr[6:0];
    assign if_ctr = bht[if_idx];
    assign ex_ctr = bht[ex_idx];
    assign train  = ready & ex_valid & ex_is_branch;

    // State register for the init/run sequencer
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_INIT;
            init_idx <= '0;
            ready    <= 1'b0;
        end else begin
            state    <= state_next;
            init_idx <= init_idx_next;
            ready    <= ready_next;
        end
    end

    // Next-state: step the sweep index and leave INIT after the last entry
    always_comb begin
        state_next    = state;
        init_idx_next = init_idx;
        ready_next    = 1'b0;
        case (state)
            ST_INIT: begin
                init_idx_next = init_idx + 1'b1;
                if (init_idx == IDX_BITS'(ENTRIES - 1)) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                state_next = ST_RUN;
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
        ready_next = (state_next == ST_RUN);
    end

    // Saturating update of the counter addressed by the resolved PC
    always_comb begin
        ex_ctr_upd = ex_ctr;
        if (ex_taken) begin
            if (ex_ctr != 2'b11) begin
                ex_ctr_upd = ex_ctr + 2'b01;
            end
        end else begin
            if (ex_ctr != 2'b00) begin
                ex_ctr_upd = ex_ctr - 2'b01;
            end
        end
    end

    // Table writes: the sweep owns the table during INIT, training owns it in RUN
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_INIT) begin
                bht[init_idx] <= INIT_CTR;
            end else if (train) begin
                bht[ex_idx] <= ex_ctr_upd;
            end
        end
    end

    // Same-cycle prediction; the table read sees the value before this edge's write
    always_comb begin
        pred_taken  = ready & if_valid &
                      (((if_opc == OPC_BRANCH) & if_ctr[1]) | (if_opc == OPC_JAL));
        pred_target = pred_taken ? (if_pc + if_imm) : (if_pc + 32'd4);
    end

    // Wrapping statistics counters, frozen while the table is being swept
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (ready) begin
            if (ex_valid && ex_is_branch) begin
                stat_branches <= stat_branches + STAT_W'(1);
            end
            if (ex_valid && ex_mispredict) begin
                stat_mispredicts <= stat_mispredicts + STAT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_bht_branch_predictor.sv
// Directed bench for bht_branch_predictor. A second instance with 4-bit stats
// shares the stimulus so that counter wrap can be reached in a few cycles.
module tb_bht_branch_predictor;

    localparam logic [31:0] BEQ  = 32'h0000_0063;
    localparam logic [31:0] JAL  = 32'h0000_006F;
    localparam logic [31:0] JALR = 32'h0000_0067;
    localparam logic [31:0] ADDI = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [31:0] if_imm;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_is_branch;
    logic        ex_taken;
    logic        ex_mispredict;
    logic        ready;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    logic        unused_pt_w;
    logic [31:0] unused_ptg_w;
    logic        unused_rdy_w;
    logic [3:0]  sb_w;
    logic [3:0]  sm_w;

    int n_pass;
    int n_total;
    int exp_br;
    int exp_mis;

    bht_branch_predictor dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_imm(if_imm),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_is_branch(ex_is_branch),
        .ex_taken(ex_taken), .ex_mispredict(ex_mispredict),
        .ready(ready), .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    bht_branch_predictor #(.STAT_W(4)) dut_w (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_imm(if_imm),
        .pred_taken(unused_pt_w), .pred_target(unused_ptg_w),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_is_branch(ex_is_branch),
        .ex_taken(ex_taken), .ex_mispredict(ex_mispredict),
        .ready(unused_rdy_w), .stat_branches(sb_w), .stat_mispredicts(sm_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] imm);
        if_valid = 1'b1;
        if_pc    = pc;
        if_instr = instr;
        if_imm   = imm;
        #1;
    endtask

    task automatic clear_ex();
        ex_valid      = 1'b0;
        ex_is_branch  = 1'b0;
        ex_taken      = 1'b0;
        ex_mispredict = 1'b0;
    endtask

    // One-cycle branch resolution during RUN; the expected stat counts follow it
    task automatic train(input logic [31:0] pc, input logic taken, input logic mis);
        ex_valid      = 1'b1;
        ex_pc         = pc;
        ex_is_branch  = 1'b1;
        ex_taken      = taken;
        ex_mispredict = mis;
        tick();
        clear_ex();
        exp_br++;
        if (mis) exp_mis++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        fetch(32'h100, BEQ, 32'h8);
        repeat (3) tick();
        n_total++; if (ready !== 1'b0) $display("FAIL rst_ready got %0b exp 0", ready); else n_pass++;
        n_total++; if (stat_branches !== 32'd0) $display("FAIL rst_stat_br got %0h exp 0", stat_branches); else n_pass++;
        n_total++; if (stat_mispredicts !== 32'd0) $display("FAIL rst_stat_mis got %0h exp 0", stat_mispredicts); else n_pass++;
        n_total++; if (pred_target !== 32'h104) $display("FAIL rst_target got %0h exp 104", pred_target); else n_pass++;
        rst = 1'b0;
        exp_br  = 0;
        exp_mis = 0;
        for (int c = 0; c <= 64; c++) begin
            if (c == 10) begin
                fetch(32'h100, BEQ, 32'h8);
                n_total++; if (pred_taken !== 1'b0) $display("FAIL init_pred_taken got %0b exp 0", pred_taken); else n_pass++;
                n_total++; if (pred_target !== 32'h104) $display("FAIL init_pred_target got %0h exp 104", pred_target); else n_pass++;
            end
            n_total++;
            if (ready !== (c == 64)) $display("FAIL init_ready cycle %0d got %0b exp %0b", c, ready, (c == 64));
            else n_pass++;
            if (c < 64) tick();
        end
    endtask

    task automatic test_cold_branch();
        fetch(32'h200, BEQ, 32'hFFFF_FFF0);
        n_total++; if (pred_taken !== 1'b0) $display("FAIL cold_taken got %0b exp 0", pred_taken); else n_pass++;
        n_total++; if (pred_target !== 32'h204) $display("FAIL cold_target got %0h exp 204", pred_target); else n_pass++;
    endtask

    // Counter walk from 01: up to 11 and hold, down to 00 and hold, back to 01
    task automatic test_training();
        logic tk [14] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic ep [14] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] tgt;
        for (int i = 0; i < 14; i++) begin
            train(32'h200, tk[i], 1'b0);
            fetch(32'h200, BEQ, 32'hFFFF_FFF0);
            tgt = ep[i] ? 32'h1F0 : 32'h204;
            n_total++; if (pred_taken !== ep[i]) $display("FAIL train_taken step %0d got %0b exp %0b", i, pred_taken, ep[i]); else n_pass++;
            n_total++; if (pred_target !== tgt) $display("FAIL train_target step %0d got %0h exp %0h", i, pred_target, tgt); else n_pass++;
        end
    endtask

    task automatic test_jal_jalr();
        fetch(32'h300, JAL, 32'h40);
        n_total++; if (pred_taken !== 1'b1) $display("FAIL jal_taken got %0b exp 1", pred_taken); else n_pass++;
        n_total++; if (pred_target !== 32'h340) $display("FAIL jal_target got %0h exp 340", pred_target); else n_pass++;
        if_valid = 1'b0;
        #1;
        n_total++; if (pred_taken !== 1'b0) $display("FAIL jal_invalid_taken got %0b exp 0", pred_taken); else n_pass++;
        n_total++; if (pred_target !== 32'h304) $display("FAIL jal_invalid_target got %0h exp 304", pred_target); else n_pass++;
        fetch(32'h300, JALR, 32'h40);
        n_total++; if (pred_taken !== 1'b0) $display("FAIL jalr_taken got %0b exp 0", pred_taken); else n_pass++;
        n_total++; if (pred_target !== 32'h304) $display("FAIL jalr_target got %0h exp 304", pred_target); else n_pass++;
        fetch(32'h300, ADDI, 32'h40);
        n_total++; if (pred_taken !== 1'b0) $display("FAIL other_opc_taken got %0b exp 0", pred_taken); else n_pass++;
        // JAL resolutions at an entry holding 01 must not move it
        ex_valid     = 1'b1;
        ex_pc        = 32'h300;
        ex_is_branch = 1'b0;
        ex_taken     = 1'b1;
        tick();
        tick();
        clear_ex();
        fetch(32'h300, BEQ, 32'h40);
        n_total++; if (pred_taken !== 1'b0) $display("FAIL jal_no_train got %0b exp 0", pred_taken); else n_pass++;
        n_total++; if (stat_branches !== 32'(exp_br)) $display("FAIL jal_stat_br got %0d exp %0d", stat_branches, exp_br); else n_pass++;
    endtask

    task automatic test_hazard_alias();
        fetch(32'h400, BEQ, 32'h20);
        ex_valid     = 1'b1;
        ex_pc        = 32'h400;
        ex_is_branch = 1'b1;
        ex_taken     = 1'b1;
        #1;
        n_total++; if (pred_taken !== 1'b0) $display("FAIL hazard_same_cycle got %0b exp 0", pred_taken); else n_pass++;
        n_total++; if (pred_target !== 32'h404) $display("FAIL hazard_same_target got %0h exp 404", pred_target); else n_pass++;
        tick();
        clear_ex();
        exp_br++;
        n_total++; if (pred_taken !== 1'b1) $display("FAIL hazard_next_cycle got %0b exp 1", pred_taken); else n_pass++;
        n_total++; if (pred_target !== 32'h420) $display("FAIL hazard_next_target got %0h exp 420", pred_target); else n_pass++;
        train(32'h500, 1'b0, 1'b0);
        fetch(32'h400, BEQ, 32'h20);
        n_total++; if (pred_taken !== 1'b0) $display("FAIL alias_500_to_400 got %0b exp 0", pred_taken); else n_pass++;
        train(32'h404, 1'b1, 1'b0);
        train(32'h404, 1'b1, 1'b0);
        fetch(32'h400, BEQ, 32'h20);
        n_total++; if (pred_taken !== 1'b0) $display("FAIL neighbour_isolated got %0b exp 0", pred_taken); else n_pass++;
        fetch(32'h404, BEQ, 32'h20);
        n_total++; if (pred_taken !== 1'b1) $display("FAIL neighbour_trained got %0b exp 1", pred_taken); else n_pass++;
        n_total++; if (pred_target !== 32'h424) $display("FAIL neighbour_target got %0h exp 424", pred_target); else n_pass++;
        train(32'h0FC, 1'b1, 1'b0);
        train(32'h0FC, 1'b1, 1'b0);
        fetch(32'h0FC, BEQ, 32'h20);
        n_total++; if (pred_taken !== 1'b1) $display("FAIL top_entry got %0b exp 1", pred_taken); else n_pass++;
        fetch(32'h000, BEQ, 32'h20);
        n_total++; if (pred_taken !== 1'b0) $display("FAIL entry0_untouched got %0b exp 0", pred_taken); else n_pass++;
    endtask

    task automatic test_back_to_back();
        ex_valid     = 1'b1;
        ex_pc        = 32'h008;
        ex_is_branch = 1'b1;
        ex_taken     = 1'b1;
        tick();
        tick();
        clear_ex();
        exp_br += 2;
        train(32'h008, 1'b0, 1'b0);
        fetch(32'h008, BEQ, 32'h10);
        n_total++; if (pred_taken !== 1'b1) $display("FAIL b2b_after_one_nt got %0b exp 1", pred_taken); else n_pass++;
        train(32'h008, 1'b0, 1'b0);
        fetch(32'h008, BEQ, 32'h10);
        n_total++; if (pred_taken !== 1'b0) $display("FAIL b2b_after_two_nt got %0b exp 0", pred_taken); else n_pass++;
    endtask

    task automatic test_stats();
        n_total++; if (stat_branches !== 32'(exp_br)) $display("FAIL stats_pre_br got %0d exp %0d", stat_branches, exp_br); else n_pass++;
        train(32'h010, 1'b1, 1'b1);
        train(32'h014, 1'b0, 1'b0);
        train(32'h018, 1'b1, 1'b0);
        train(32'h01C, 1'b0, 1'b1);
        train(32'h020, 1'b1, 1'b0);
        // Qualifier off: nothing counts
        ex_is_branch  = 1'b1;
        ex_mispredict = 1'b1;
        tick();
        clear_ex();
        // Non-branch mispredict (e.g. JALR) counts only as a mispredict
        ex_valid      = 1'b1;
        ex_mispredict = 1'b1;
        tick();
        clear_ex();
        exp_mis++;
        n_total++; if (stat_branches !== 32'(exp_br)) $display("FAIL stats_br got %0d exp %0d", stat_branches, exp_br); else n_pass++;
        n_total++; if (stat_mispredicts !== 32'(exp_mis)) $display("FAIL stats_mis got %0d exp %0d", stat_mispredicts, exp_mis); else n_pass++;
        n_total++; if (sm_w !== 4'(exp_mis)) $display("FAIL stats_mis_narrow got %0d exp %0d", sm_w, 4'(exp_mis)); else n_pass++;
    endtask

    task automatic test_mid_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_br  = 0;
        exp_mis = 0;
        n_total++; if (ready !== 1'b0) $display("FAIL midrst_ready got %0b exp 0", ready); else n_pass++;
        n_total++; if (stat_branches !== 32'd0) $display("FAIL midrst_br got %0d exp 0", stat_branches); else n_pass++;
        n_total++; if (stat_mispredicts !== 32'd0) $display("FAIL midrst_mis got %0d exp 0", stat_mispredicts); else n_pass++;
        for (int c = 0; c < 64; c++) begin
            ex_valid      = 1'b1;
            ex_pc         = 32'h200;
            ex_is_branch  = 1'b1;
            ex_taken      = 1'b1;
            ex_mispredict = 1'b1;
            if (c == 5) begin
                fetch(32'h300, JAL, 32'h40);
                n_total++; if (pred_taken !== 1'b0) $display("FAIL midrst_init_jal got %0b exp 0", pred_taken); else n_pass++;
                n_total++; if (pred_target !== 32'h304) $display("FAIL midrst_init_target got %0h exp 304", pred_target); else n_pass++;
            end
            tick();
        end
        clear_ex();
        n_total++; if (ready !== 1'b1) $display("FAIL midrst_ready_back got %0b exp 1", ready); else n_pass++;
        n_total++; if (stat_branches !== 32'd0) $display("FAIL midrst_init_br got %0d exp 0", stat_branches); else n_pass++;
        n_total++; if (stat_mispredicts !== 32'd0) $display("FAIL midrst_init_mis got %0d exp 0", stat_mispredicts); else n_pass++;
        fetch(32'h200, BEQ, 32'hFFFF_FFF0);
        n_total++; if (pred_taken !== 1'b0) $display("FAIL midrst_init_train got %0b exp 0", pred_taken); else n_pass++;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 16; i++) train(32'h014, 1'b0, 1'b0);
        n_total++; if (sb_w !== 4'd0) $display("FAIL wrap_narrow got %0d exp 0", sb_w); else n_pass++;
        n_total++; if (stat_branches !== 32'd16) $display("FAIL wrap_wide got %0d exp 16", stat_branches); else n_pass++;
        train(32'h014, 1'b0, 1'b0);
        n_total++; if (sb_w !== 4'd1) $display("FAIL wrap_narrow_next got %0d exp 1", sb_w); else n_pass++;
        n_total++; if (stat_branches !== 32'(exp_br)) $display("FAIL wrap_wide_next got %0d exp %0d", stat_branches, exp_br); else n_pass++;
    endtask

    initial begin
        n_pass   = 0;
        n_total  = 0;
        exp_br   = 0;
        exp_mis  = 0;
        rst      = 1'b1;
        if_valid = 1'b0;
        if_pc    = 32'h0;
        if_instr = 32'h0;
        if_imm   = 32'h0;
        ex_pc    = 32'h0;
        clear_ex();
        test_reset();
        test_cold_branch();
        test_training();
        test_jal_jalr();
        test_hazard_alias();
        test_back_to_back();
        test_stats();
        test_mid_reset();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bht_branch_predictor.md
Name: bht_branch_predictor

Overview:
Fetch-side direction and target predictor that consumes the sign-extended immediate produced for the fetched instruction. Holds a 2-bit saturating-counter branch history table (BHT) indexed by PC, and predicts conditional branches and JAL. Execute-stage resolution trains the BHT. On reset, an init FSM sweeps the table, and performance counters track branches and mispredicts.

Parameters:
IDX_BITS, 6, log2 of BHT entries; index = pc[IDX_BITS+1:2]
INIT_CTR, 2'b01, counter value written to each entry during init (weakly not-taken)
STAT_W, 32, width of statistics counters

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
if_valid  input  1  fetch slot holds a valid instruction
if_pc  input  32  PC of fetched instruction
if_instr  input  32  fetched instruction word
if_imm  input  32  sign-extended immediate for if_instr (B-type/J-type offset)
pred_taken  output  1  predicted redirect
pred_target  output  32  predicted next PC
ex_valid  input  1  resolution info valid this cycle
ex_pc  input  32  PC of resolved instruction
ex_is_branch  input  1  resolved instruction is a conditional branch (opcode 1100011)
ex_taken  input  1  actual branch outcome
ex_mispredict  input  1  execute detected a misprediction
ready  output  1  init sweep done; predictor active
stat_branches  output  STAT_W  resolved conditional branches counted
stat_mispredicts  output  STAT_W  mispredicts counted

Behaviour:
- FSM states: INIT and RUN. rst forces INIT, sweep index 0, both stat counters 0, ready 0.
- INIT: one entry per cycle, written with INIT_CTR, starting at entry 0 in the first cycle with rst=0. After the last entry (2^IDX_BITS-1) is written, the FSM moves to RUN. ready=1 from cycle 2^IDX_BITS after rst deasserts (64 with defaults).
- ready is a registered output: 1 in RUN, 0 in INIT.
- Prediction is combinational in the same cycle; the BHT read is asynchronous.
  - opc = if_instr[6:0]; ctr = BHT[if_pc[IDX_BITS+1:2]].
  - pred_taken = ready & if_valid & ((opc==1100011 & ctr[1]) | opc==1101111).
  - pred_target = pred_taken ? if_pc + if_imm : if_pc + 4. Both sums are 32-bit and wrap modulo 2^32.
  - JALR (1100111) and all other opcodes: pred_taken=0.
  - During INIT or reset: pred_taken=0 and pred_target=if_pc+4.
- Training: only when ready & ex_valid & ex_is_branch. Entry BHT[ex_pc[IDX_BITS+1:2]] is updated at the clock edge.
  - ex_taken=1: increment, saturating at 2'b11.
  - ex_taken=0: decrement, saturating at 2'b00.
  - JAL never trains.
- Same-cycle predict and train on the same index: the prediction uses the pre-update value (read-before-write). The new value is visible next cycle.
- Stats, both updated only when ready:
  - stat_branches increments on ex_valid & ex_is_branch.
  - stat_mispredicts increments on ex_valid & ex_mispredict.
  - Both wrap at 2^STAT_W with no saturation and no flag.
- ex_valid events during INIT are dropped: no training and no stat change.
- rst asserted mid-RUN or mid-INIT: on the next edge the FSM returns to INIT at index 0, stats clear, and ready drops. The sweep restarts from scratch, and previous table contents are irrelevant because the sweep overwrites them.
- Entries alias by index. Tags are not stored, so different PCs sharing an index share a counter.

Test Plan:
- Reset/init: hold rst 3 cycles, release -> ready=0 for cycles 0..63, ready=1 at cycle 64. During init, a BEQ at pc 0x100 gives pred_taken=0 and pred_target=0x104.
- Cold branch: after ready, if_pc=0x200, if_instr=BEQ, if_imm=0xFFFFFFF0 -> pred_taken=0, pred_target=0x204.
- Training and saturation at pc 0x200: one taken resolution gives ctr=10 -> pred_taken=1, pred_target=0x1F0. Four more taken leave ctr=11. One not-taken gives 10, which still predicts taken. Two more not-taken give 00, then not-taken. Three more not-taken stay at 00.
- JAL/JALR: JAL at 0x300 with imm 0x40 -> pred_taken=1, target=0x340 regardless of BHT. JALR -> pred_taken=0, target=0x304. A JAL resolution with ex_is_branch=0 leaves the BHT and stat_branches unchanged.
- Same-cycle hazard and aliasing: predict and train-taken at 0x400 with ctr=01 -> the prediction that cycle is not-taken, and 0x400 predicts taken next cycle. Then train 0x500 (same index with IDX_BITS=6: 0x400>>2=0x100 and 0x500>>2=0x140 share low 6 bits) not-taken -> 0x400 is affected.
- Stats and mid-run reset: 5 branch resolutions with 2 mispredicts -> stat_branches=5, stat_mispredicts=2. Assert rst 1 cycle -> both read 0, ready=0, and ex events during the next 64 cycles do not count. Preload stat_branches=0xFFFFFFFF and count one branch -> it wraps to 0.
